damage_encoder: RTL and testbench
=================================

# damage_encoder

Per-round damage aggregator, the producer side of the damage decode path. On a round start it snapshots every attacker's (valid, target, damage) request, sums the damage per target (16 units plus the tower) over a sequential scan, then streams one `(select, total)` pair per cycle for each target that took damage. The top level uses two instances:
- Enemy attackers drive `unitDamageSelect`/`totalUnitDamage`.
- Friendly attackers drive `enemyDamageSelect`/`totalEnemyDamage`.

## Interface
Parameters:
- `N_ATT`, 16, number of attackers (fixed at 16 in this design).
- `DMG_W`, 8, per-attacker damage width.
- `TOT_W`, 12, accumulated total width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_start`  in  1  round-start pulse; honored only in IDLE.
- `attack_valid`  in  16  bit i: attacker i attacks this round.
- `attack_target`  in  80  attacker i target at `[5i+4:5i]`; values 0–15 select a unit, 16–31 select the tower.
- `attack_damage`  in  128  attacker i damage at `[8i+7:8i]`.
- `damage_select`  out  5  target of the current output; 0–15 for units, 16 for the tower.
- `total_damage`  out  12  accumulated damage for `damage_select`.
- `damage_valid`  out  1  output pair is meaningful this cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of the round.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Reset values:
  - State IDLE.
  - All accumulators 0.
  - `damage_select` = 16, `total_damage` = 0, `damage_valid` = 0, `busy` = 0, `done` = 0.
- IDLE → SCAN on `frame_start`:
  - Snapshot all three attack vectors into registers.
  - Clear the 17 accumulators.
  - Set `idx` = 0.
- SCAN, one attacker per cycle, `idx` 0..15:
  - If `valid[idx]` and `damage != 0`, update `acc[t] = sat(acc[t] + damage)`.
  - `t` = target when target < 16; otherwise `t` = 16.
  - After `idx` = 15: go to DRAIN with `idx` = 0.
- DRAIN, one target per cycle, `idx` 0..16:
  - Register `select` = `idx` and `total` = `acc[idx]`.
  - Register `damage_valid` = (`acc[idx] != 0`).
  - When `acc[idx] == 0`, drive the idle pair instead: `select` 16, `total` 0.
  - After `idx` = 16: go to DONE.
- DONE:
  - Register the idle output pair, `damage_valid` 0, `done` 1.
  - Return to IDLE.
- Outputs that are not valid always carry total 0, so a downstream decoder applies no damage.
- Saturation: sums clamp at 4095. This is unreachable at default parameters (max 16×255 = 4080) and is required for generality.
- No clamping to 8 bits here; the decoder clamps to 255.
- `frame_start` is ignored in SCAN, DRAIN and DONE.
- Input changes after the snapshot have no effect on the round in progress.
- Reset mid-round returns to reset values immediately; no `done` pulse is produced.

## Timing
- E0 = the edge that samples `frame_start` high in IDLE.
- E1..E16: attackers 0..15 accumulated.
- E17+j (j = 0..16): output for target j is registered and visible for one cycle after that edge.
- E34: idle pair plus `done` = 1 are visible for one cycle; state is IDLE.
- `busy` is high from after E0 through the cycle after E33, and low from E34.
- Round length is a fixed 34 cycles. The next `frame_start` is accepted at E35 or later.
- All outputs are registered.

## Structure
- Shared package `damage_pkg`:
  - `N_UNITS` = 16, `SEL_W` = 5, `TOWER_SEL` = 5'd16, `DMG_W`, `TOT_W`.
  - State encoding.
- Sub-module `damage_sat_add`: combinational TOT_W + DMG_W saturating adder, one instance shared across SCAN.
- Accumulators are a 17×12 register array indexed by the mapped target.

## Test plan
- Reset asserted mid-DRAIN → outputs are select 16, total 0, valid 0, busy 0 on the next sample; the next round shows no stale totals.
- Attacker 3 → target 5, damage 40, all others invalid → exactly one valid pulse after E22 (select 5, total 40); `done` after E34.
- Attackers 0, 7, 15 → target 2 with damage 200, 200, 100 → one pulse after E19 (select 2, total 500).
- Attacker 1 → target 16, damage 10; attacker 9 → target 31, damage 20 → tower pulse after E33 (select 16, total 30).
- All 16 attackers → target 7, damage 255 → select 7, total 4080. Separately, force `damage_sat_add` with 4090 + 10 → result 4095.
- `frame_start` re-pulsed at E10 and inputs changed at E5 → ignored; results match the E0 snapshot and a single `done` pulse occurs.

Source files
------------

// File: rtl/damage_pkg.sv
// Shared constants, state encoding and target mapping for the damage encode path.
package damage_pkg;
  localparam int N_UNITS = 16;
  localparam int SEL_W   = 5;
  localparam int DMG_W   = 8;
  localparam int TOT_W   = 12;
  localparam logic [SEL_W-1:0] TOWER_SEL = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Targets 16..31 all collapse onto the single tower accumulator.
  function automatic logic [SEL_W-1:0] map_target(input logic [SEL_W-1:0] t);
    return t[SEL_W-1] ? TOWER_SEL : t;
  endfunction
endpackage

// File: rtl/damage_sat_add.sv
// Combinational accumulator + damage adder that clamps at the all-ones total.
module damage_sat_add #(
  parameter int TOT_W = 12,
  parameter int DMG_W = 8
) (
  input  logic [TOT_W-1:0] a,
  input  logic [DMG_W-1:0] b,
  output logic [TOT_W-1:0] sum
);
  logic [TOT_W:0] wide;

  assign wide = {1'b0, a} + {{(TOT_W + 1 - DMG_W){1'b0}}, b};
  assign sum  = wide[TOT_W] ? {TOT_W{1'b1}} : wide[TOT_W-1:0];
endmodule

// File: rtl/damage_encoder.sv
// Per-round damage aggregator: snapshot attackers, scan-sum per target, then
// stream one (select, total) pair per damaged target.
module damage_encoder #(
  parameter int N_ATT = 16,
  parameter int DMG_W = 8,
  parameter int TOT_W = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [N_ATT-1:0]       attack_valid,
  input  logic [5*N_ATT-1:0]     attack_target,
  input  logic [DMG_W*N_ATT-1:0] attack_damage,
  output logic [4:0]             damage_select,
  output logic [TOT_W-1:0]       total_damage,
  output logic                   damage_valid,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             debug_state
);
  import damage_pkg::*;

  // damage_valid qualifies (damage_select, total_damage) for exactly one cycle;
  // there is no ready, the consumer must take every valid pair as it appears.

  localparam logic [4:0] SCAN_LAST = 5'(N_ATT - 1);

  state_t state, state_nxt;

  logic [N_ATT-1:0]       valid_q;
  logic [5*N_ATT-1:0]     target_q;
  logic [DMG_W*N_ATT-1:0] damage_q;
  logic [TOT_W-1:0]       acc [0:N_UNITS];
  logic [4:0]             idx;

  logic             cur_valid;
  logic [4:0]       cur_tgt;
  logic [DMG_W-1:0] cur_dmg;
  logic [4:0]       cur_slot;
  logic [TOT_W-1:0] acc_sum;

  assign cur_valid = valid_q[idx[3:0]];
  assign cur_tgt   = target_q[5*idx[3:0] +: 5];
  assign cur_dmg   = damage_q[DMG_W*idx[3:0] +: DMG_W];
  assign cur_slot  = map_target(cur_tgt);

  damage_sat_add #(.TOT_W(TOT_W), .DMG_W(DMG_W)) u_sat_add (
    .a  (acc[cur_slot]),
    .b  (cur_dmg),
    .sum(acc_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = S_SCAN;
      S_SCAN:  if (idx == SCAN_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (idx == TOWER_SEL) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      target_q      <= '0;
      damage_q      <= '0;
      idx           <= '0;
      for (int j = 0; j <= N_UNITS; j++) acc[j] <= '0;
      damage_select <= TOWER_SEL;
      total_damage  <= '0;
      damage_valid  <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Idle pair unless a damaged target is being drained this cycle.
      damage_select <= TOWER_SEL;
      total_damage  <= '0;
      damage_valid  <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            valid_q  <= attack_valid;
            target_q <= attack_target;
            damage_q <= attack_damage;
            idx      <= '0;
            for (int j = 0; j <= N_UNITS; j++) acc[j] <= '0;
          end
        end
        S_SCAN: begin
          if (cur_valid && (cur_dmg != '0)) acc[cur_slot] <= acc_sum;
          idx <= (idx == SCAN_LAST) ? 5'd0 : idx + 5'd1;
        end
        S_DRAIN: begin
          if (acc[idx] != '0) begin
            damage_select <= idx;
            total_damage  <= acc[idx];
            damage_valid  <= 1'b1;
          end
          idx <= (idx == TOWER_SEL) ? 5'd0 : idx + 5'd1;
        end
        S_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign debug_state = state;
endmodule

// File: tb/tb_damage_encoder.sv
// Bench for damage_encoder: table of rounds, random rounds, mid-round corner cases.
module tb_damage_encoder;
  import damage_pkg::*;

  localparam int W = 23; // {edge[5:0], select[4:0], total[11:0]}

  typedef struct {
    logic [15:0]  v;
    logic [79:0]  t;
    logic [127:0] d;
    int           exp_cnt;
    int           exp_sel;
    int           exp_tot;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         frame_start = 1'b0;
  logic [15:0]  attack_valid = '0;
  logic [79:0]  attack_target = '0;
  logic [127:0] attack_damage = '0;
  logic [4:0]   damage_select;
  logic [11:0]  total_damage;
  logic         damage_valid;
  logic         busy;
  logic         done;
  logic [1:0]   debug_state;

  logic [11:0]  sat_a;
  logic [7:0]   sat_b;
  logic [11:0]  sat_y;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  damage_encoder dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .attack_valid(attack_valid), .attack_target(attack_target),
    .attack_damage(attack_damage), .damage_select(damage_select),
    .total_damage(total_damage), .damage_valid(damage_valid),
    .busy(busy), .done(done), .debug_state(debug_state)
  );

  damage_sat_add #(.TOT_W(12), .DMG_W(8)) u_sat (.a(sat_a), .b(sat_b), .sum(sat_y));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t att(input vec_t v, input int i, input int tgt, input int dmg);
    vec_t r = v;
    r.v[i] = 1'b1;
    r.t[5*i +: 5] = 5'(tgt);
    r.d[8*i +: 8] = 8'(dmg);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    r.v = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 16; i++) begin
      r.t[5*i +: 5] = 5'($urandom_range(0, 31));
      r.d[8*i +: 8] = 8'($urandom_range(0, 255));
    end
    r.exp_cnt = -1; r.exp_sel = -1; r.exp_tot = -1;
    return r;
  endfunction

  // Reference totals from the snapshot; pushes one expected pulse per damaged target.
  task automatic push_expected(input vec_t v);
    int s[17];
    for (int j = 0; j < 17; j++) s[j] = 0;
    for (int i = 0; i < 16; i++) begin
      int tg, dm;
      tg = int'(v.t[5*i +: 5]);
      dm = int'(v.d[8*i +: 8]);
      if (tg > 15) tg = 16;
      if (v.v[i] && dm != 0) s[tg] = (s[tg] + dm > 4095) ? 4095 : s[tg] + dm;
    end
    for (int j = 0; j < 17; j++)
      if (s[j] != 0) exp_q.push_back({6'(17 + j), 5'(j), 12'(s[j])});
  endtask

  task automatic run_round(input vec_t v, input int change_at, input int repulse_at,
                           output int npulse, output int fsel, output int ftot);
    vec_t r;
    logic [W-1:0] e;
    npulse = 0; fsel = -1; ftot = -1;
    push_expected(v);
    @(negedge clk);
    attack_valid = v.v; attack_target = v.t; attack_damage = v.d;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("busy_after_e0", busy, 1);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (damage_valid) begin
        if (npulse == 0) begin fsel = damage_select; ftot = total_damage; end
        npulse++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got edge %0d sel %0d tot %0d expected none",
                   k, damage_select, total_damage);
        end else begin
          e = exp_q.pop_front();
          n_cmp--;
          check("pulse", {k[5:0], damage_select, total_damage}, 32'(e));
        end
      end else begin
        check("idle_pair", {damage_select, total_damage}, {5'd16, 12'd0});
      end
      check("busy", busy, (k < 34) ? 1 : 0);
      check("done", done, (k == 34) ? 1 : 0);
      if (k == change_at) begin
        r = rand_vec();
        attack_valid = r.v; attack_target = r.t; attack_damage = r.d;
      end
      frame_start = (k + 1 == repulse_at);
    end
    frame_start = 1'b0;
    check("leftover_expected", exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t tbl[6];
  vec_t z;
  int np, fs, ft;

  initial begin
    z.v = '0; z.t = '0; z.d = '0; z.exp_cnt = 0; z.exp_sel = -1; z.exp_tot = -1;
    tbl[0] = att(z, 3, 5, 40);
    tbl[0].exp_cnt = 1; tbl[0].exp_sel = 5; tbl[0].exp_tot = 40;
    tbl[1] = att(att(att(z, 0, 2, 200), 7, 2, 200), 15, 2, 100);
    tbl[1].exp_cnt = 1; tbl[1].exp_sel = 2; tbl[1].exp_tot = 500;
    tbl[2] = att(att(z, 1, 16, 10), 9, 31, 20);
    tbl[2].exp_cnt = 1; tbl[2].exp_sel = 16; tbl[2].exp_tot = 30;
    tbl[3] = z;
    for (int i = 0; i < 16; i++) tbl[3] = att(tbl[3], i, 7, 255);
    tbl[3].exp_cnt = 1; tbl[3].exp_sel = 7; tbl[3].exp_tot = 4080;
    tbl[4] = att(att(z, 2, 4, 0), 5, 0, 1);
    tbl[4].d[8*4 +: 8] = 8'd50;
    tbl[4].t[5*4 +: 5] = 5'd4;
    tbl[4].exp_cnt = 1; tbl[4].exp_sel = 0; tbl[4].exp_tot = 1;
    tbl[5] = z;
    tbl[5].d = {16{8'd99}};

    // Reset state
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_select", damage_select, 16);
    check("rst_total", total_damage, 0);
    check("rst_valid", damage_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", debug_state, S_IDLE);
    reset = 1'b0;

    // Saturating adder
    sat_a = 12'd4090; sat_b = 8'd10; #1 check("sat_4090_10", sat_y, 4095);
    sat_a = 12'd4000; sat_b = 8'd95; #1 check("sat_4000_95", sat_y, 4095);
    sat_a = 12'd4000; sat_b = 8'd94; #1 check("sat_4000_94", sat_y, 4094);
    sat_a = 12'd0;    sat_b = 8'd255; #1 check("sat_0_255", sat_y, 255);

    for (int i = 0; i < 6; i++) begin
      run_round(tbl[i], 0, 0, np, fs, ft);
      check("tbl_count", np, tbl[i].exp_cnt);
      check("tbl_sel", fs, tbl[i].exp_sel);
      check("tbl_tot", ft, tbl[i].exp_tot);
    end

    for (int i = 0; i < 3; i++) run_round(rand_vec(), 0, 0, np, fs, ft);

    // Inputs changed at E5 and frame_start re-pulsed at E10: snapshot must hold.
    run_round(tbl[1], 5, 10, np, fs, ft);
    check("late_count", np, 1);
    check("late_tot", ft, 500);

    // Reset in the middle of DRAIN, then a fresh round must show no stale totals.
    @(negedge clk);
    attack_valid = tbl[3].v; attack_target = tbl[3].t; attack_damage = tbl[3].d;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_select", damage_select, 16);
    check("midrst_total", total_damage, 0);
    check("midrst_valid", damage_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk) reset = 1'b0;
    run_round(att(z, 0, 5, 7), 0, 0, np, fs, ft);
    check("post_rst_count", np, 1);
    check("post_rst_sel", fs, 5);
    check("post_rst_tot", ft, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
